fifo_byte_drain: RTL and testbench

FIFO_BYTE_DRAIN -- requirements
Module: fifo_byte_drain

---
 rtl/fifo_drain_pkg.sv | 29 ++
 rtl/fifo_byte_drain.sv | 110 +++++++++++
 tb/tb_fifo_byte_drain.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_drain_pkg.sv
// Shared state encodings, byte width and checksum helper for the FIFO byte drain.
// Combinational helpers only, no latency, no flow control.
package fifo_drain_pkg;

    localparam int BYTE_W     = 8;
    localparam int MAX_WORD_W = 1024;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_SEND = 2'd2
`ifdef FIFO_BYTE_DRAIN_CSUM_EN
        ,
        ST_CSUM = 2'd3
`endif
    } state_t;

    // XOR of the low nbytes bytes of a word; words narrower than MAX_WORD_W are zero-extended.
    function automatic logic [BYTE_W-1:0] word_csum(input logic [MAX_WORD_W-1:0] word,
                                                    input int                    nbytes);
        logic [BYTE_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < MAX_WORD_W / BYTE_W; i++) begin
            if (i < nbytes) acc = acc ^ word[i*BYTE_W +: BYTE_W];
        end
        return acc;
    endfunction

endpackage

// File: rtl/fifo_byte_drain.sv
// Pops WIDTH-bit words from an external FIFO and streams them LSB byte first (checksum byte when FIFO_BYTE_DRAIN_CSUM_EN).
// WIDTH/8+2 cycles per word at full ready; tx_ready_i low holds the current byte and valid stable.
module fifo_byte_drain
    import fifo_drain_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             enable_i,
    input  logic             fifo_empty_i,
    output logic             fifo_rd_o,
    input  logic [WIDTH-1:0] fifo_data_i,
    output logic             tx_valid_o,
    input  logic             tx_ready_i,
    output logic [7:0]       tx_data_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] words_sent_o
);

    localparam int NB    = WIDTH / BYTE_W;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] shift_q;
    logic [IDX_W-1:0] idx_q;
    logic [CNT_W-1:0] cnt_q;
    logic             last_byte;
    logic             word_done;
`ifdef FIFO_BYTE_DRAIN_CSUM_EN
    logic [BYTE_W-1:0] csum_q;
`endif

    assign last_byte    = (idx_q == LAST_IDX);
    assign busy_o       = (state_q != ST_IDLE);
    assign words_sent_o = cnt_q;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) state_q <= ST_IDLE;
        else           state_q <= state_d;
    end

    // reset_ni gates the pop so the FIFO is never drained while the block is held in reset.
    always_comb begin
        state_d    = state_q;
        fifo_rd_o  = 1'b0;
        tx_valid_o = 1'b0;
        tx_data_o  = '0;
        word_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (reset_ni && enable_i && !fifo_empty_i) begin
                    fifo_rd_o = 1'b1;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: state_d = ST_SEND;
            ST_SEND: begin
                tx_valid_o = 1'b1;
                tx_data_o  = shift_q[BYTE_W-1:0];
                if (tx_ready_i && last_byte) begin
`ifdef FIFO_BYTE_DRAIN_CSUM_EN
                    state_d   = ST_CSUM;
`else
                    state_d   = ST_IDLE;
                    word_done = 1'b1;
`endif
                end
            end
`ifdef FIFO_BYTE_DRAIN_CSUM_EN
            ST_CSUM: begin
                tx_valid_o = 1'b1;
                tx_data_o  = csum_q;
                if (tx_ready_i) begin
                    state_d   = ST_IDLE;
                    word_done = 1'b1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            shift_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
`ifdef FIFO_BYTE_DRAIN_CSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            if (state_q == ST_WAIT) begin
                shift_q <= fifo_data_i;
                idx_q   <= '0;
`ifdef FIFO_BYTE_DRAIN_CSUM_EN
                csum_q  <= word_csum(MAX_WORD_W'(fifo_data_i), NB);
`endif
            end else if (state_q == ST_SEND && tx_ready_i && !last_byte) begin
                shift_q <= shift_q >> BYTE_W;
                idx_q   <= idx_q + 1'b1;
            end
            if (word_done) cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_byte_drain.sv
// Directed bench for fifo_byte_drain with a small FIFO model (pop data valid the cycle after fifo_rd_o).
module tb_fifo_byte_drain;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;
    localparam int NB    = WIDTH / 8;
`ifdef FIFO_BYTE_DRAIN_CSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic             clk = 1'b0;
    logic             reset_ni;
    logic             enable_i;
    logic             fifo_empty_i;
    logic             fifo_rd_o;
    logic [WIDTH-1:0] fifo_data_i = '0;
    logic             tx_valid_o;
    logic             tx_ready_i;
    logic [7:0]       tx_data_o;
    logic             busy_o;
    logic [CNT_W-1:0] words_sent_o;

    int checks = 0;
    int errors = 0;
    int rd_empty_cnt = 0;
    int rd_noen_cnt = 0;

    logic [31:0] mem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;

    initial forever #5 clk = ~clk;

    fifo_byte_drain #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk_i        (clk),
        .reset_ni     (reset_ni),
        .enable_i     (enable_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_rd_o    (fifo_rd_o),
        .fifo_data_i  (fifo_data_i),
        .tx_valid_o   (tx_valid_o),
        .tx_ready_i   (tx_ready_i),
        .tx_data_o    (tx_data_o),
        .busy_o       (busy_o),
        .words_sent_o (words_sent_o)
    );

    assign fifo_empty_i = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_o && fifo_empty_i) rd_empty_cnt <= rd_empty_cnt + 1;
        if (fifo_rd_o && !enable_i)    rd_noen_cnt  <= rd_noen_cnt + 1;
        if (fifo_rd_o && !fifo_empty_i) begin
            fifo_data_i <= mem[rd_ptr];
            rd_ptr      <= rd_ptr + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] w);
        mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    // Streams one word out, checking each byte; stall applies ready 1,0,0,1,0,0...
    task automatic drain_word(input logic [31:0] w, input bit stall, input int drop_en_k,
                              input string tag);
        logic [7:0] exp_b;
        int cyc;
        int wt;
        bit done;
        cyc = 0;
        for (int k = 0; k < NB + CS; k++) begin
            if (k < NB) exp_b = w[8*k +: 8];
            else        exp_b = w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
            wt = 0;
            while (tx_valid_o !== 1'b1 && wt < 20) begin
                @(negedge clk);
                wt++;
            end
            if (k > 0 && !stall) check({tag, " gap"}, 32'(wt), 32'd0);
            done = 1'b0;
            while (!done) begin
                tx_ready_i = stall ? (cyc % 3 == 0) : 1'b1;
                check({tag, " valid"}, 32'(tx_valid_o), 32'd1);
                check({tag, " byte"}, 32'(tx_data_o), 32'(exp_b));
                cyc++;
                done = tx_ready_i;
                @(negedge clk);
            end
            if (k == drop_en_k) enable_i = 1'b0;
        end
        tx_ready_i = 1'b1;
    endtask

    initial begin
        int wt;
        logic [31:0] w;
        reset_ni   = 1'b0;
        enable_i   = 1'b1;
        tx_ready_i = 1'b1;
        push(32'h44332211);
        repeat (2) @(negedge clk);

        check("rst valid", 32'(tx_valid_o), 32'd0);
        check("rst data", 32'(tx_data_o), 32'd0);
        check("rst busy", 32'(busy_o), 32'd0);
        check("rst words", 32'(words_sent_o), 32'd0);
        check("rst rd", 32'(fifo_rd_o), 32'd0);

        reset_ni = 1'b1;
        #1;
        check("idle rd", 32'(fifo_rd_o), 32'd1);
        check("idle busy", 32'(busy_o), 32'd0);
        @(negedge clk);
        check("wait busy", 32'(busy_o), 32'd1);
        check("wait valid", 32'(tx_valid_o), 32'd0);
        check("wait rd", 32'(fifo_rd_o), 32'd0);

        drain_word(32'h44332211, 1'b0, -1, "w0");
        check("w0 end valid", 32'(tx_valid_o), 32'd0);
        check("w0 end busy", 32'(busy_o), 32'd0);
        check("w0 words", 32'(words_sent_o), 32'd1);

        push(32'h44332211);
        drain_word(32'h44332211, 1'b1, -1, "stall");
        check("stall words", 32'(words_sent_o), 32'd2);

        push(32'hA3A2A1A0);
        push(32'hB3B2B1B0);
        push(32'hC3C2C1C0);
        drain_word(32'hA3A2A1A0, 1'b0, 1, "enA");
        check("enA words", 32'(words_sent_o), 32'd3);
        check("enA busy", 32'(busy_o), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("en low rd", 32'(fifo_rd_o), 32'd0);
            @(negedge clk);
        end
        check("en low queued", 32'(fifo_empty_i), 32'd0);
        check("en low idle", 32'(busy_o), 32'd0);
        enable_i = 1'b1;
        drain_word(32'hB3B2B1B0, 1'b0, -1, "enB");
        drain_word(32'hC3C2C1C0, 1'b0, -1, "enC");
        check("enC words", 32'(words_sent_o), 32'd5);

        push(32'h0D0C0B0A);
        wt = 0;
        while (tx_valid_o !== 1'b1 && wt < 20) begin
            @(negedge clk);
            wt++;
        end
        check("mid b0", 32'(tx_data_o), 32'h0A);
        @(negedge clk);
        check("mid b1", 32'(tx_data_o), 32'h0B);
        @(negedge clk);
        check("mid b2", 32'(tx_data_o), 32'h0C);
        check("mid b2 valid", 32'(tx_valid_o), 32'd1);
        reset_ni = 1'b0;
        #1;
        check("mrst valid", 32'(tx_valid_o), 32'd0);
        check("mrst data", 32'(tx_data_o), 32'd0);
        check("mrst busy", 32'(busy_o), 32'd0);
        check("mrst words", 32'(words_sent_o), 32'd0);
        check("mrst rd", 32'(fifo_rd_o), 32'd0);
        @(negedge clk);
        reset_ni = 1'b1;
        #1;
        check("post rst valid", 32'(tx_valid_o), 32'd0);
        @(negedge clk);
        check("post rst idle valid", 32'(tx_valid_o), 32'd0);
        check("post rst idle busy", 32'(busy_o), 32'd0);
        push(32'h87654321);
        drain_word(32'h87654321, 1'b0, -1, "fresh");
        check("fresh words", 32'(words_sent_o), 32'd1);

        for (int i = 0; i < 15; i++) begin
            w = 32'h5A3C0F96 ^ (32'(i) * 32'h01030507);
            push(w);
            drain_word(w, 1'b0, -1, "wrap");
            repeat (2) begin
                check("gap rd", 32'(fifo_rd_o), 32'd0);
                @(negedge clk);
            end
        end
        check("wrap to zero", 32'(words_sent_o), 32'd0);
        push(32'hFEDCBA98);
        drain_word(32'hFEDCBA98, 1'b0, -1, "w17");
        check("wrap words", 32'(words_sent_o), 32'd1);
        check("rd while empty", 32'(rd_empty_cnt), 32'd0);
        check("rd while disabled", 32'(rd_noen_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
